sap_controller: RTL



---
 rtl/sap_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sap_controller.sv
// SAP-1 control sequencer: decodes the one-hot T-state and the latched opcode into the
// 12-bit control word, holds the halt latch and the retired-instruction counter.
// Optional T-state sanity checker: define SAP_CTRL_ONEHOT_CHK_EN.
`timescale 1ns/1ps

module sap_controller #(
   parameter int ICNT_W = 8
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic [5:0]        t,
   input  logic [3:0]        ir_op,
   output logic [11:0]       con,
   output logic              hlt,
   output logic              err,
   output logic [ICNT_W-1:0] icount
);

   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T6 = 6'b100000;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [11:0] CON_CP = 12'h800;
   localparam logic [11:0] CON_EP = 12'h400;
   localparam logic [11:0] CON_LM = 12'h200;
   localparam logic [11:0] CON_CE = 12'h100;
   localparam logic [11:0] CON_LI = 12'h080;
   localparam logic [11:0] CON_EI = 12'h040;
   localparam logic [11:0] CON_LA = 12'h020;
   localparam logic [11:0] CON_EA = 12'h010;
   localparam logic [11:0] CON_SU = 12'h008;
   localparam logic [11:0] CON_EU = 12'h004;
   localparam logic [11:0] CON_LB = 12'h002;
   localparam logic [11:0] CON_LO = 12'h001;

   logic [3:0]        r_op;
   logic              r_hlt;
   logic [ICNT_W-1:0] r_icount;
   logic              w_hlt_t4;
   logic              w_force0;
   logic [11:0]       w_x4;
   logic [11:0]       w_x5;
   logic [11:0]       w_x6;
   logic [11:0]       w_con_raw;

`ifdef SAP_CTRL_ONEHOT_CHK_EN
   logic r_err;
   logic w_onehot;

   function automatic logic f_onehot(input logic [5:0] v);
      return (v != 6'b000000) && ((v & (v - 6'b000001)) == 6'b000000);
   endfunction

   assign w_onehot = f_onehot(t);
   assign w_force0 = r_hlt | r_err | ~w_onehot;
   assign err      = r_err;
`else
   assign w_force0 = r_hlt;
   assign err      = 1'b0;
`endif

   assign w_hlt_t4 = t[3] & (r_op == OP_HLT);

   // Sequencer state; everything moves on the falling edge so the datapath sees settled values.
   always_ff @(negedge clk or negedge res_n) begin
      if (!res_n) begin
         r_op     <= 4'b0000;
         r_hlt    <= 1'b0;
         r_icount <= {ICNT_W{1'b0}};
`ifdef SAP_CTRL_ONEHOT_CHK_EN
         r_err    <= 1'b0;
`endif
      end else begin
         if (t == T3) begin
            r_op <= ir_op;
         end
         if (w_hlt_t4) begin
            r_hlt <= 1'b1;
         end
         if ((t == T6) && !r_hlt) begin
            r_icount <= r_icount + ICNT_W'(1);
         end
`ifdef SAP_CTRL_ONEHOT_CHK_EN
         if (!w_onehot) begin
            r_err <= 1'b1;
         end
`endif
      end
   end

   // Execute-phase words per opcode; NOP and HLT drive nothing in T4..T6.
   always_comb begin
      w_x4 = 12'h000;
      w_x5 = 12'h000;
      w_x6 = 12'h000;
      case (r_op)
         OP_LDA: begin
            w_x4 = CON_EI | CON_LM;
            w_x5 = CON_CE | CON_LA;
         end
         OP_ADD: begin
            w_x4 = CON_EI | CON_LM;
            w_x5 = CON_CE | CON_LB;
            w_x6 = CON_LA | CON_EU;
         end
         OP_SUB: begin
            w_x4 = CON_EI | CON_LM;
            w_x5 = CON_CE | CON_LB;
            w_x6 = CON_LA | CON_SU | CON_EU;
         end
         OP_OUT: begin
            w_x4 = CON_EA | CON_LO;
         end
         default: begin
            w_x4 = 12'h000;
            w_x5 = 12'h000;
            w_x6 = 12'h000;
         end
      endcase
   end

   // Per-bit OR keeps multi-hot t meaningful when the checker is compiled out.
   assign w_con_raw = ({12{t[0]}} & (CON_EP | CON_LM))
                    | ({12{t[1]}} & CON_CP)
                    | ({12{t[2]}} & (CON_CE | CON_LI))
                    | ({12{t[3]}} & w_x4)
                    | ({12{t[4]}} & w_x5)
                    | ({12{t[5]}} & w_x6);

   assign con    = w_force0 ? 12'h000 : w_con_raw;
   assign hlt    = r_hlt | w_hlt_t4;
   assign icount = r_icount;

endmodule
